bias_sequencer: RTL and testbench
=================================

BIAS_SEQUENCER -- requirements
Module: bias_sequencer

Interface
REQ-001 Parameter N_adder_tree, default 16: number of 18-bit lanes per beat.
REQ-002 Parameter NUM_GROUPS, default 4: filter groups per layer pass; each group has its own bias vector.
REQ-003 Parameter PIX_PER_GROUP, default 8: beats accepted per group before the group index advances.
REQ-004 Parameter RELU, default 0: 1 enables clamp-to-zero of negative results.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse; begins a layer pass.
REQ-009 in_data  input  N_adder_tree*18  adder-tree sums; lane i occupies bits [18*(i+1)-1:18*i]; two's complement.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  block accepts in_data this cycle.
REQ-012 bias_sel  output  max(1,clog2(NUM_GROUPS))  index of the current group; drives the external bias-bank mux.
REQ-013 bias_in  input  N_adder_tree*18  bias vector for bias_sel, same lane packing; combinational from bias_sel.
REQ-014 out_data  output  N_adder_tree*18  biased, saturated result.
REQ-015 out_valid  output  1  out_data valid.
REQ-016 out_ready  input  1  downstream accepts out_data.
REQ-017 busy  output  1  high from the start acceptance until done.
REQ-018 done  output  1  one-cycle pulse after the last beat of the pass leaves the output stage.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on acceptance of beat NUM_GROUPS*PIX_PER_GROUP; DRAIN->IDLE on final output handshake, with done=1 in that same cycle.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-022 Input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-023 On input handshake, per lane: out = sat18(in_data lane + bias_in lane), registered; latency exactly 1 cycle to out_valid.
REQ-024 Addition SHALL be 19-bit signed; results >131071 saturate to 18'h1FFFF; results <-131072 saturate to 18'h20000.
REQ-025 RELU=1: a negative saturated result SHALL become 0.
REQ-026 bias_in SHALL be sampled in the handshake cycle, using the bias_sel value current in that cycle.
REQ-027 Pixel counter increments on each input handshake; at PIX_PER_GROUP-1 it wraps to 0 and bias_sel increments.
REQ-028 After the last group, bias_sel wraps to 0.
REQ-029 out_valid rises on input handshake; it clears on an output handshake with no simultaneous input handshake.
REQ-030 Simultaneous input and output handshake SHALL load new data, holding out_valid=1.
REQ-031 out_data SHALL be held stable while out_valid && !out_ready.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 rst_n low, at any time including mid-pass, SHALL asynchronously force: state IDLE, counters 0, bias_sel 0, out_valid 0, out_data 0, done 0, in_ready 0, busy 0.
REQ-034 After reset release, nothing is accepted until a start pulse.

Verification
REQ-035 Defaults; start; 32 beats, lane0=100, bias_in lane0 = 50*(bias_sel+1); out_ready=1 -> lane0 outputs 150 (x8), 200, 250, 300; bias_sel 0,1,2,3,0; done exactly once, in the cycle of the 32nd output.
REQ-036 lane0 in=131000, bias=200 -> 18'h1FFFF; in=-131000, bias=-200 -> 18'h20000; in=-5, bias=3: RELU=0 -> -2, RELU=1 -> 0.
REQ-037 out_ready held 0 for 5 cycles with a beat pending -> in_ready=0, out_data stable, no beat lost; the pass still completes with 32 outputs in order.
REQ-038 in_valid toggled randomly, out_ready random at 50% -> output sequence matches the reference model; bias_sel advances only after every 8th accepted beat.
REQ-039 rst_n pulled low after beat 13 -> all outputs are at their reset values immediately; a new start yields bias_sel=0 and a full 32-beat pass.
REQ-040 start pulsed during RUN -> ignored; counters and bias_sel are not disturbed.

Source files
------------

// File: rtl/bias_sequencer.sv
// Bias-add / saturate stage behind the adder tree: sequences bias groups over a layer pass
// and presents one registered, biased beat per accepted input beat.
module bias_sequencer #(
   parameter int N_adder_tree  = 16,
   parameter int NUM_GROUPS    = 4,
   parameter int PIX_PER_GROUP = 8,
   parameter int RELU          = 0
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  start,
   input  logic [N_adder_tree*18-1:0]                            in_data,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   output logic [((NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1)-1:0] bias_sel,
   input  logic [N_adder_tree*18-1:0]                            bias_in,
   output logic [N_adder_tree*18-1:0]                            out_data,
   output logic                                                  out_valid,
   input  logic                                                  out_ready,
   output logic                                                  busy,
   output logic                                                  done
);

   localparam int DW = N_adder_tree * 18;
   localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [PW-1:0]   pix_r;
   logic [GW-1:0]   sel_r;
   logic            out_valid_r;
   logic [DW-1:0]   out_data_r;
   logic [DW-1:0]   sat_s;
   logic            in_ready_s;
   logic            in_hs_s;
   logic            out_hs_s;
   logic            pix_wrap_s;
   logic            sel_wrap_s;
   logic            last_beat_s;
   logic            start_acc_s;
   logic            done_s;

   // Sign-extended 19-bit add; overflow shows as disagreement of the top two sum bits.
   function automatic logic [17:0] sat18(input logic [17:0] a, input logic [17:0] b);
      logic [18:0] sum;
      logic [17:0] res;
      sum = {a[17], a} + {b[17], b};
      if (sum[18] != sum[17]) begin
         res = sum[18] ? 18'h20000 : 18'h1FFFF;
      end else begin
         res = sum[17:0];
      end
      if ((RELU != 0) && res[17]) begin
         res = 18'h00000;
      end else begin
         res = res;
      end
      return res;
   endfunction

   // Handshake qualifiers and group/pixel wrap conditions.
   always_comb begin
      in_ready_s  = (state_r == RUN) && (!out_valid_r || out_ready);
      in_hs_s     = in_valid && in_ready_s;
      out_hs_s    = out_valid_r && out_ready;
      pix_wrap_s  = (pix_r == PW'(PIX_PER_GROUP - 1));
      sel_wrap_s  = (sel_r == GW'(NUM_GROUPS - 1));
      last_beat_s = in_hs_s && pix_wrap_s && sel_wrap_s;
      start_acc_s = (state_r == IDLE) && start;
   end

   // Pass-level FSM next state; done fires on the final output handshake.
   always_comb begin
      state_nxt_s = state_r;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = RUN;
            else       state_nxt_s = IDLE;
         end
         RUN: begin
            if (last_beat_s) state_nxt_s = DRAIN;
            else             state_nxt_s = RUN;
         end
         DRAIN: begin
            if (out_hs_s) begin
               state_nxt_s = IDLE;
               done_s      = 1'b1;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Pixel and group counters; the group index is what the external bias bank decodes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_r <= '0;
         sel_r <= '0;
      end else if (start_acc_s) begin
         pix_r <= '0;
         sel_r <= '0;
      end else if (in_hs_s) begin
         if (pix_wrap_s) begin
            pix_r <= '0;
            sel_r <= sel_wrap_s ? '0 : sel_r + GW'(1);
         end else begin
            pix_r <= pix_r + PW'(1);
         end
      end
   end

   // Per-lane biased and saturated sum of the current input beat.
   always_comb begin
      sat_s = '0;
      for (int i = 0; i < N_adder_tree; i++) begin
         sat_s[i*18 +: 18] = sat18(in_data[i*18 +: 18], bias_in[i*18 +: 18]);
      end
   end

   // Output register: loads on every accepted beat, otherwise holds until drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else if (in_hs_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= sat_s;
      end else if (out_hs_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign bias_sel  = sel_r;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign busy      = (state_r != IDLE);
   assign done      = done_s;

endmodule

// File: tb/tb_bias_sequencer.sv
// Randomized bench for bias_sequencer: two instances (RELU off/on) share stimulus and are
// compared against a queue-based model of whole-pass behaviour.
module tb_bias_sequencer;

   localparam int N     = 16;
   localparam int NG    = 4;
   localparam int PPG   = 8;
   localparam int TOTAL = NG * PPG;
   localparam int W     = N * 18;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          out_ready;
   logic          in_ready_a, in_ready_b;
   logic [1:0]    bias_sel_a, bias_sel_b;
   logic [W-1:0]  bias_in_a, bias_in_b;
   logic [W-1:0]  out_data_a, out_data_b;
   logic          out_valid_a, out_valid_b;
   logic          busy_a, busy_b;
   logic          done_a, done_b;

   logic [W-1:0]  bias_bank [NG];
   logic [W-1:0]  beat_data [TOTAL];

   int            n_total = 0;
   int            n_bad   = 0;
   int            m_state;      // 0 idle, 1 accepting, 2 draining
   bit            m_ov;
   int            m_acc;
   int            out_cnt;
   int            done_cnt;
   logic [W-1:0]  q0 [$];
   logic [W-1:0]  q1 [$];

   always #5 clk = ~clk;

   assign bias_in_a = bias_bank[bias_sel_a];
   assign bias_in_b = bias_bank[bias_sel_b];

   bias_sequencer #(.N_adder_tree(N), .NUM_GROUPS(NG), .PIX_PER_GROUP(PPG), .RELU(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_a), .bias_sel(bias_sel_a), .bias_in(bias_in_a), .out_data(out_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a), .done(done_a));

   bias_sequencer #(.N_adder_tree(N), .NUM_GROUPS(NG), .PIX_PER_GROUP(PPG), .RELU(1)) u_dut_relu (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_b), .bias_sel(bias_sel_b), .bias_in(bias_in_b), .out_data(out_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b), .done(done_b));

   task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic [W-1:0] b,
                                             input bit relu);
      logic [W-1:0]       r;
      logic signed [17:0] da, ba;
      int                 s;
      r = '0;
      for (int i = 0; i < N; i++) begin
         da = d[i*18 +: 18];
         ba = b[i*18 +: 18];
         s  = int'(da) + int'(ba);
         if (s > 131071)  s = 131071;
         if (s < -131072) s = -131072;
         if (relu && s < 0) s = 0;
         r[i*18 +: 18] = 18'(s);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[i*18 +: 18] = 18'($urandom);
      return v;
   endfunction

   task automatic prep_pass(input int mode);
      for (int g = 0; g < NG; g++) bias_bank[g] = rand_vec();
      for (int k = 0; k < TOTAL; k++) beat_data[k] = rand_vec();
      if (mode == 0) begin
         for (int g = 0; g < NG; g++) bias_bank[g][17:0] = 18'(50 * (g + 1));
         for (int k = 0; k < TOTAL; k++) beat_data[k][17:0] = 18'd100;
      end else if (mode == 1) begin
         bias_bank[0][17:0] = 18'(200);
         bias_bank[1][17:0] = 18'(-200);
         bias_bank[2][17:0] = 18'(3);
         for (int k = 0; k < 3 * PPG; k++) begin
            if (k < PPG)          beat_data[k][17:0] = 18'(131000);
            else if (k < 2 * PPG) beat_data[k][17:0] = 18'(-131000);
            else                  beat_data[k][17:0] = 18'(-5);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_in_ready"},  in_ready_a | in_ready_b, 1'b0);
      check_val({tag, "_bias_sel"},  {bias_sel_a, bias_sel_b}, 4'd0);
      check_val({tag, "_out_valid"}, out_valid_a | out_valid_b, 1'b0);
      check_val({tag, "_out_data"},  out_data_a | out_data_b, '0);
      check_val({tag, "_busy"},      busy_a | busy_b, 1'b0);
      check_val({tag, "_done"},      done_a | done_b, 1'b0);
   endtask

   // One clock of stimulus; the model advances using only bench-side knowledge.
   task automatic step(input bit st, input bit iv, input bit orr);
      bit exp_ir, ihs, ohs, exp_done;
      @(negedge clk);
      start     = st;
      in_valid  = iv;
      out_ready = orr;
      in_data   = (m_acc < TOTAL) ? beat_data[m_acc] : rand_vec();
      #1;
      exp_ir   = (m_state == 1) && (!m_ov || orr);
      ihs      = iv && exp_ir;
      ohs      = m_ov && orr;
      exp_done = ohs && (m_state == 2) && (q0.size() == 1);
      check_val("in_ready",    in_ready_a,  exp_ir);
      check_val("in_ready_r",  in_ready_b,  exp_ir);
      check_val("busy",        busy_a,      m_state != 0);
      check_val("out_valid",   out_valid_a, m_ov);
      check_val("out_valid_r", out_valid_b, m_ov);
      check_val("done",        done_a,      exp_done);
      check_val("done_r",      done_b,      exp_done);
      if (done_a) done_cnt++;
      if (m_ov && q0.size() > 0) begin
         check_val("out_data",      out_data_a, q0[0]);
         check_val("out_data_relu", out_data_b, q1[0]);
      end
      if (ihs) begin
         check_val("bias_sel",   bias_sel_a, (m_acc / PPG) % NG);
         check_val("bias_sel_r", bias_sel_b, (m_acc / PPG) % NG);
         q0.push_back(ref_beat(beat_data[m_acc], bias_bank[m_acc / PPG], 1'b0));
         q1.push_back(ref_beat(beat_data[m_acc], bias_bank[m_acc / PPG], 1'b1));
         m_acc++;
      end
      if (ohs && q0.size() > 0) begin
         void'(q0.pop_front());
         void'(q1.pop_front());
         out_cnt++;
      end
      if (st && m_state == 0) begin
         m_state  = 1;
         m_acc    = 0;
         out_cnt  = 0;
         done_cnt = 0;
      end else if (ihs && m_acc == TOTAL) begin
         m_state = 2;
      end else if (exp_done) begin
         m_state = 0;
      end
      if (ihs)      m_ov = 1'b1;
      else if (ohs) m_ov = 1'b0;
   endtask

   task automatic do_reset_mid();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      start    = 1'b0;
      #1;
      check_reset_outputs("midreset");
      q0.delete();
      q1.delete();
      m_state = 0;
      m_ov    = 1'b0;
      m_acc   = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_pass(input int mode, input int ivp, input int orp,
                           input int stall_at, input int start_at, input int rst_at);
      int cyc, stall_cnt;
      bit stall_done, start_done, aborted, iv, orr, st;
      cyc = 0; stall_cnt = 0; stall_done = 0; start_done = 0; aborted = 0;
      prep_pass(mode);
      step(1'b1, 1'b0, 1'b1);
      while (m_state != 0 && cyc < 3000 && !aborted) begin
         iv  = ($urandom_range(99) < ivp);
         orr = ($urandom_range(99) < orp);
         st  = 1'b0;
         if (stall_cnt > 0) begin
            iv = 1'b1; orr = 1'b0; stall_cnt--;
         end else if (!stall_done && m_acc == stall_at && m_ov) begin
            iv = 1'b1; orr = 1'b0; stall_cnt = 4; stall_done = 1'b1;
         end
         if (!start_done && m_acc == start_at) begin
            st = 1'b1; start_done = 1'b1;
         end
         if (m_acc == rst_at) begin
            do_reset_mid();
            aborted = 1'b1;
         end else begin
            step(st, iv, orr);
         end
         cyc++;
      end
      if (!aborted) begin
         check_val("pass_timeout", cyc < 3000, 1'b1);
         check_val("done_once",    done_cnt,   1);
         check_val("out_count",    out_cnt,    TOTAL);
         @(negedge clk);
         #1;
         check_val("bias_sel_end", bias_sel_a, 2'd0);
         check_val("busy_end",     busy_a,     1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      for (int g = 0; g < NG; g++) bias_bank[g] = '0;
      m_state = 0; m_ov = 1'b0; m_acc = 0; out_cnt = 0; done_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b1, 1'b1);

      run_pass(0, 100, 100, -1, -1, -1);
      run_pass(1, 100, 100, -1, -1, -1);
      run_pass(2, 100, 100,  6, -1, -1);
      run_pass(2,  70,  50, -1, 10, -1);
      run_pass(2,  60,  50, -1, -1, -1);
      run_pass(2, 100, 100, -1, -1, 13);
      repeat (3) step(1'b0, 1'b1, 1'b1);
      run_pass(2,  80,  60, -1, -1, -1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
